// File: rtl/binary_cell.sv
// Single-word storage cell for the lab RAM array: a flip-flop register written on
// the clock edge and read out combinationally, forced to zero when not being read.
module binary_cell #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] DIn,
    input  logic             cs,
    input  logic             w,
    input  logic             r,
    output logic [WIDTH-1:0] DOut
);

    logic [WIDTH-1:0] q_reg;
    logic             write_en;
    logic             read_en;

    assign write_en = cs & w;
    assign read_en  = cs & r;

    // Reset has priority over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RESET_VALUE;
        end else if (write_en) begin
            q_reg <= DIn;
        end
    end

    // Unselected or idle cells drive zero so that the array can OR all DOut lines.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_read
            assign DOut[gi] = q_reg[gi] & read_en;
        end
    endgenerate

endmodule

// File: tb/tb_binary_cell.sv
// Self-checking bench for binary_cell: directed checks for the specified scenarios
// plus randomized traffic compared every cycle against a behavioural model.
module tb_binary_cell;

    localparam logic [7:0] RV8 = 8'h3C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs  = 1'b0;
    logic       w   = 1'b0;
    logic       r   = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout8;
    logic [0:0] dout1;
    logic [0:0] din1;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q8;
    logic       model_q1;
    logic       model_valid = 1'b0;
    logic       compare_en  = 1'b0;

    assign din1 = din[0];

    always #5 clk = ~clk;

    binary_cell #(.WIDTH(8), .RESET_VALUE(RV8)) u_cell8 (
        .clk (clk),
        .rst (rst),
        .DIn (din),
        .cs  (cs),
        .w   (w),
        .r   (r),
        .DOut(dout8)
    );

    binary_cell u_cell1 (
        .clk (clk),
        .rst (rst),
        .DIn (din1),
        .cs  (cs),
        .w   (w),
        .r   (r),
        .DOut(dout1)
    );

    // Reference: the stored word changes only on reset or a selected write.
    always @(posedge clk) begin
        if (rst) begin
            model_q8    <= RV8;
            model_q1    <= 1'b0;
            model_valid <= 1'b1;
        end else if (cs && w) begin
            model_q8    <= din;
            model_q1    <= din[0];
            model_valid <= 1'b1;
        end
    end

    function automatic logic [7:0] exp8();
        return (cs && r) ? model_q8 : 8'h00;
    endfunction

    function automatic logic exp1();
        return (cs && r) ? model_q1 : 1'b0;
    endfunction

    always @(negedge clk) begin
        if (compare_en && model_valid) begin
            total++;
            if (dout8 !== exp8()) begin
                bad++;
                $display("FAIL model8 t=%0t cs=%b w=%b r=%b got=%h want=%h",
                         $time, cs, w, r, dout8, exp8());
            end
            total++;
            if (dout1 !== exp1()) begin
                bad++;
                $display("FAIL model1 t=%0t cs=%b w=%b r=%b got=%b want=%b",
                         $time, cs, w, r, dout1, exp1());
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got8, input logic [7:0] want8,
                         input logic got1, input logic want1);
        total++;
        if (got8 !== want8 || got1 !== want1) begin
            bad++;
            $display("FAIL %s got8=%h want8=%h got1=%b want1=%b", name, got8, want8, got1, want1);
        end else begin
            $display("ok   %s dout8=%h dout1=%b", name, got8, got1);
        end
    endtask

    // Apply new inputs shortly after a rising edge, then let them settle.
    task automatic drive(input logic rst_i, input logic cs_i, input logic w_i,
                         input logic r_i, input logic [7:0] din_i);
        @(posedge clk);
        #2;
        rst = rst_i;
        cs  = cs_i;
        w   = w_i;
        r   = r_i;
        din = din_i;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset for one edge, then read
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        compare_en = 1'b1;
        check("reset_read", dout8, RV8, dout1[0], 1'b0);

        // cs low blocks writes; cs low forces DOut to zero
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
        repeat (3) after_edge();
        r = 1'b1;
        #1;
        check("cs_low_read", dout8, 8'h00, dout1[0], 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
        check("cs_blocked_write", dout8, RV8, dout1[0], 1'b0);

        // read old value before the edge, new value after it
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
        check("rw_before_edge", dout8, 8'h00, dout1[0], 1'b0);
        after_edge();
        check("rw_after_edge", dout8, 8'hFF, dout1[0], 1'b1);

        // no write without w
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        repeat (3) after_edge();
        check("hold_no_w", dout8, 8'hFF, dout1[0], 1'b1);

        // overwrite with zero, then cs low writes are ignored
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        after_edge();
        check("write_zero", dout8, 8'h00, dout1[0], 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
        after_edge();
        check("cs_low_idle", dout8, 8'h00, dout1[0], 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("cs_low_held", dout8, 8'h00, dout1[0], 1'b0);

        // wide word write, read gating, reset during active read
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("read_a5", dout8, 8'hA5, dout1[0], 1'b1);
        r = 1'b0;
        #1;
        check("r_low", dout8, 8'h00, dout1[0], 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        check("pre_reset_read", dout8, 8'hA5, dout1[0], 1'b1);
        after_edge();
        check("reset_mid_read", dout8, RV8, dout1[0], 1'b0);

        // randomized traffic checked by the model on every cycle
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 8'($urandom));
        end
        after_edge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/binary_cell.md
Name: binary_cell

Overview:
- Single-word storage cell, the basic building block of the lab RAM array. One cell per bit, or per word with WIDTH > 1.
- Chip-select gates all access. A write stores DIn on the clock edge. A read drives the stored value onto DOut combinationally.
- Array logic tiles many cells and combines their DOut lines by OR, so an unselected cell must drive zero.

Parameters:
- WIDTH, default 1, data width in bits of DIn, DOut and the storage register.
- RESET_VALUE, default 0 (WIDTH bits), value loaded into storage on reset.

Ports:
- clk, input, 1, system clock; all state changes occur on its rising edge.
- rst, input, 1, synchronous active-high reset.
- DIn, input, WIDTH, write data.
- cs, input, 1, chip select, active-high; when low the cell is inert.
- w, input, 1, write enable, active-high, qualified by cs.
- r, input, 1, read enable, active-high, qualified by cs.
- DOut, output, WIDTH, read data; all zeros when not reading.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. The polarity and synchronicity are fixed.
- Storage: internal register Q[WIDTH-1:0].
- Reset: when rst=1 at a rising clk edge, Q <= RESET_VALUE. Reset has priority over write.
  - DOut is never registered, so it follows the read rule below using the reset Q value from the following cycle.
- Write: when rst=0, cs=1 and w=1 at a rising clk edge, Q <= DIn. Latency is 1 edge.
- Hold: in every other case Q keeps its value.
  - cs=0 blocks writes regardless of w.
  - w=0 blocks writes.
- Read: DOut = (cs & r) ? Q : 0, purely combinational with zero-cycle latency. w has no influence on whether a read happens.
- Read and write together (cs=1, w=1, r=1):
  - Before the edge, DOut shows the old Q.
  - After the edge, DOut shows the new Q (= DIn sampled at that edge).
  - There is no write-through bypass: DIn never propagates directly to DOut.
- cs=0 with r=1: DOut = 0.
- X handling: no reset is required before use in simulation. Before the first reset or write, Q is unknown and a read returns X. Benches must reset or write first.
- DIn changing between edges has no effect on Q. Only the value present at the rising edge is sampled.
- Reset during an active read: DOut shows RESET_VALUE immediately after the reset edge while cs=1 and r=1.
- No internal clock gating; clk runs continuously.
- No latches: storage is a flip-flop register, not an SR latch.

Test Plan:
- rst=1 for one edge, then cs=1, r=1, w=0 -> DOut = 0 (RESET_VALUE).
- cs=0, w=1, DIn=1, r=0 across several edges, then cs=1, r=1, w=0 -> DOut still 0 (write blocked by cs). Also during cs=0 with r=1 -> DOut = 0.
- cs=1, w=1, DIn=0, r=0 for one edge, then DIn=1, w=1, r=1 -> DOut = 0 before the edge and 1 after it (read-old-then-new).
- cs=1, w=0, r=1, DIn=0 over several edges after storing 1 -> DOut stays 1 (no write without w).
- cs=1, w=1, r=1, DIn=0 -> DOut becomes 0 after the edge. Then cs=0, w=1, r=0, DIn=1 for two edges -> Q remains 0, and DOut = 0.
- With WIDTH=8: write 8'hA5 (cs=1, w=1), then read with cs=1, r=1 -> DOut = 8'hA5. Deassert r -> DOut = 8'h00. Assert rst mid-read -> DOut = RESET_VALUE after the edge.
